// File: rtl/unstripe_lane_scheduler_if.sv
// Lane-side and stream-side signals of the unstripe lane scheduler.
// The master drives lanes/enable; the slave (scheduler) drives the output stream and status.
interface unstripe_lane_scheduler_if #(
  parameter int unsigned DATA_W = 32
);
  logic              enable;
  logic [DATA_W-1:0] lane0;
  logic              valid_0;
  logic [DATA_W-1:0] lane1;
  logic              valid_1;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic              lane_sel;
  logic              skew_err;
  logic              fifo_ovf;
  logic [1:0]        state;

  modport master (
    output enable, lane0, valid_0, lane1, valid_1,
    input  data_out, valid_out, lane_sel, skew_err, fifo_ovf, state
  );

  modport slave (
    input  enable, lane0, valid_0, lane1, valid_1,
    output data_out, valid_out, lane_sel, skew_err, fifo_ovf, state
  );
endinterface

// File: rtl/unstripe_lane_scheduler.sv
// Two-lane receive scheduler: per-lane FIFOs, ALIGN-phase deskew, strict lane0/lane1
// alternating pop onto one registered word stream, with sticky skew/overflow flags.
module unstripe_lane_scheduler #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned SKEW_MAX   = 3
) (
  input  logic                    clk_2f,
  input  logic                    reset,
  unstripe_lane_scheduler_if.slave bus
);
  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = (SKEW_MAX > 1) ? $clog2(SKEW_MAX + 1) : 1;

  typedef enum logic [1:0] {StIdle = 2'd0, StAlign = 2'd1, StRun = 2'd2, StDrain = 2'd3} st_e;

  st_e               st_q, st_d;
  logic              nxt_q, nxt_d;
  logic [SW-1:0]     skc_q, skc_d;
  logic              skew_err_q, skew_err_d;
  logic              fifo_ovf_q, fifo_ovf_d;
  logic              valid_out_q, valid_out_d;
  logic              lane_sel_q, lane_sel_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic [DATA_W-1:0] mem_q [2][FIFO_DEPTH];
  logic [DATA_W-1:0] mem_d [2][FIFO_DEPTH];
  logic [AW-1:0]     wptr_q [2];
  logic [AW-1:0]     wptr_d [2];
  logic [AW-1:0]     rptr_q [2];
  logic [AW-1:0]     rptr_d [2];
  logic [CW-1:0]     cnt_q [2];
  logic [CW-1:0]     cnt_d [2];

  logic [DATA_W-1:0] din [2];
  logic [1:0]        vin, wr, wr_ok, pop, ne;
  logic              flush, ovf;

  assign din[0] = bus.lane0;
  assign din[1] = bus.lane1;
  assign vin    = {bus.valid_1, bus.valid_0};

  always_comb begin
    st_d        = st_q;
    nxt_d       = nxt_q;
    skc_d       = skc_q;
    skew_err_d  = skew_err_q;
    fifo_ovf_d  = fifo_ovf_q;
    valid_out_d = 1'b0;
    lane_sel_d  = lane_sel_q;
    data_out_d  = data_out_q;
    mem_d       = mem_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    cnt_d       = cnt_q;
    flush       = 1'b0;
    ovf         = 1'b0;
    pop         = 2'b00;
    wr          = 2'b00;
    wr_ok       = 2'b00;
    ne          = 2'b00;

    if ((st_q == StRun || st_q == StDrain) && cnt_q[nxt_q] != '0) pop[nxt_q] = 1'b1;

    for (int l = 0; l < 2; l++) begin
      ne[l]    = (cnt_q[l] != '0);
      wr[l]    = vin[l] && (st_q != StIdle);
      // A full FIFO accepts a write only when it is popped in the same cycle
      wr_ok[l] = wr[l] && ((cnt_q[l] != CW'(FIFO_DEPTH)) || pop[l]);
      if (wr[l] && !wr_ok[l]) ovf = 1'b1;
      if (wr_ok[l]) begin
        mem_d[l][wptr_q[l]] = din[l];
        wptr_d[l]           = wptr_q[l] + 1'b1;
      end
      if (pop[l]) rptr_d[l] = rptr_q[l] + 1'b1;
      cnt_d[l] = cnt_q[l] + CW'(wr_ok[l]) - CW'(pop[l]);
    end

    if (pop != 2'b00) begin
      data_out_d  = mem_q[nxt_q][rptr_q[nxt_q]];
      valid_out_d = 1'b1;
      lane_sel_d  = nxt_q;
      nxt_d       = ~nxt_q;
    end

    unique case (st_q)
      StIdle: begin
        if (bus.enable) st_d = StAlign;
      end
      StAlign: begin
        if (!bus.enable) begin
          st_d  = StIdle;
          flush = 1'b1;
          skc_d = '0;
        end else if (ne == 2'b11) begin
          st_d  = StRun;
          skc_d = '0;
          nxt_d = 1'b0;
        end else if (ne != 2'b00) begin
          if (skc_q == SW'(SKEW_MAX - 1)) begin
            skew_err_d = 1'b1;
            flush      = 1'b1;
            skc_d      = '0;
          end else begin
            skc_d = skc_q + 1'b1;
          end
        end else begin
          skc_d = '0;
        end
      end
      StRun: begin
        if (!bus.enable) st_d = StDrain;
      end
      StDrain: begin
        if (bus.enable) begin
          st_d = StRun;
        end else if (pop == 2'b00) begin
          // Lane in turn ran dry: the other lane's leftovers can never be paired
          flush = 1'b1;
          nxt_d = 1'b0;
          st_d  = StIdle;
        end
      end
    endcase

    if (ovf) begin
      fifo_ovf_d = 1'b1;
      flush      = 1'b1;
      nxt_d      = 1'b0;
      skc_d      = '0;
      st_d       = bus.enable ? StAlign : StIdle;
    end

    if (flush) begin
      for (int l = 0; l < 2; l++) begin
        wptr_d[l] = '0;
        rptr_d[l] = '0;
        cnt_d[l]  = '0;
      end
    end
  end

  always_ff @(posedge clk_2f or posedge reset) begin
    if (reset) begin
      st_q        <= StIdle;
      nxt_q       <= 1'b0;
      skc_q       <= '0;
      skew_err_q  <= 1'b0;
      fifo_ovf_q  <= 1'b0;
      valid_out_q <= 1'b0;
      lane_sel_q  <= 1'b0;
      data_out_q  <= '0;
      mem_q       <= '{default: '0};
      wptr_q      <= '{default: '0};
      rptr_q      <= '{default: '0};
      cnt_q       <= '{default: '0};
    end else begin
      st_q        <= st_d;
      nxt_q       <= nxt_d;
      skc_q       <= skc_d;
      skew_err_q  <= skew_err_d;
      fifo_ovf_q  <= fifo_ovf_d;
      valid_out_q <= valid_out_d;
      lane_sel_q  <= lane_sel_d;
      data_out_q  <= data_out_d;
      mem_q       <= mem_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.valid_out = valid_out_q;
  assign bus.lane_sel  = lane_sel_q;
  assign bus.skew_err  = skew_err_q;
  assign bus.fifo_ovf  = fifo_ovf_q;
  assign bus.state     = st_q;
endmodule
